// File: rtl/dp_ram16k_fifo_ctrl.sv
// dp_ram16k_fifo_ctrl
// FIFO controller around one DP_RAM16K macro (active-low wen/ren, 1-cycle
// registered read). A 2-entry skid buffer after the RAM gives the pop side
// first-word-fall-through valid/ready behaviour.
module dp_ram16k_fifo_ctrl #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 9,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned AF_LEVEL = 500
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   level,
    output logic          almost_full,
    output logic          empty,
    output logic          ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_d_in,
    output logic [DW-1:0] ram_wenb,
    output logic          ram_ren,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_d_out
);

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   AF_L    = (AW+1)'(AF_LEVEL);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   ram_cnt;
    logic          rd_pend;
    logic [1:0]    ob_cnt;
    logic [DW-1:0] ob_head;
    logic [DW-1:0] ob_tail;

    logic          push;
    logic          pop;
    logic          rd;

    // Handshakes, read-issue decision and RAM port drive.
    always_comb begin
        in_ready  = !rst && (ram_cnt != DEPTH_L);
        push      = in_valid && in_ready;
        out_valid = !rst && (ob_cnt != 2'd0);
        pop       = out_valid && out_ready;
        // Issue only if the word still fits in the skid buffer once it lands,
        // counting the read already in flight and this cycle's pop.
        rd        = !rst && (ram_cnt != '0) &&
                    (({1'b0, ob_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));

        ram_wen   = !push;
        ram_waddr = wptr;
        ram_d_in  = in_data;
        ram_wenb  = '1;
        ram_ren   = !rd;
        ram_raddr = rptr;

        out_data    = ob_head;
        level       = ram_cnt + (AW+1)'(rd_pend) + (AW+1)'(ob_cnt);
        almost_full = (level >= AF_L);
        empty       = (level == '0);
    end

    // Pointers, RAM occupancy, in-flight read flag and skid-buffer count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            ob_cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
            if (rd) begin
                rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
            end
            ram_cnt <= ram_cnt + (AW+1)'(push) - (AW+1)'(rd);
            rd_pend <= rd;
            ob_cnt  <= ob_cnt - {1'b0, pop} + {1'b0, rd_pend};
        end
    end

    // Skid-buffer data: pop shifts tail to head, then the returning RAM word
    // lands in the first free slot after that shift.
    always_ff @(posedge clk) begin
        if (pop) begin
            ob_head <= ob_tail;
        end
        if (rd_pend) begin
            if ((ob_cnt - {1'b0, pop}) == 2'd0) begin
                ob_head <= ram_d_out;
            end else begin
                ob_tail <= ram_d_out;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram16k_fifo_ctrl.sv
// tb_dp_ram16k_fifo_ctrl
// Directed bench for the FIFO controller, with a behavioural 512x32 RAM
// (active-low enables, registered read) attached to the RAM port.
module tb_dp_ram16k_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic          almost_full;
    logic          empty;
    logic          ram_wen;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_d_in;
    logic [DW-1:0] ram_wenb;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_d_out;

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [0:511];

    dp_ram16k_fifo_ctrl #(
        .DW(32), .AW(9), .DEPTH(512), .AF_LEVEL(500)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .almost_full(almost_full), .empty(empty),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_d_in(ram_d_in),
        .ram_wenb(ram_wenb), .ram_ren(ram_ren), .ram_raddr(ram_raddr),
        .ram_d_out(ram_d_out)
    );

    always #5 clk = ~clk;

    // RAM model: masked write, registered read.
    always @(posedge clk) begin
        if (ram_wen == 1'b0)
            mem[ram_waddr] <= (mem[ram_waddr] & ~ram_wenb) | (ram_d_in & ram_wenb);
        if (ram_ren == 1'b0)
            ram_d_out <= mem[ram_raddr];
    end

    // A location must never be read in the cycle it is written.
    always @(negedge clk) begin
        if (rst === 1'b0 && ram_wen === 1'b0 && ram_ren === 1'b0) begin
            vectors++;
            if (ram_waddr === ram_raddr) begin
                miscompares++;
                $display("FAIL rw_same_addr: waddr=%0d raddr=%0d required different", ram_waddr, ram_raddr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = '0;
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || ram_wen !== 1'b1 || ram_ren !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b wen=%b ren=%b required 0 0 1 1",
                     in_ready, out_valid, ram_wen, ram_ren);
        end
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (level !== 10'd0 || empty !== 1'b1 || almost_full !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: level=%0d empty=%b af=%b in_ready=%b out_valid=%b required 0 1 0 1 0",
                     level, empty, almost_full, in_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_first_word();
        in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (ram_wen !== 1'b0 || ram_waddr !== 9'd0 || ram_d_in !== 32'hA5A5_0001 || ram_wenb !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL first_write: wen=%b waddr=%0d d_in=%h wenb=%h required 0 0 a5a50001 ffffffff",
                     ram_wen, ram_waddr, ram_d_in, ram_wenb);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (ram_ren !== 1'b0 || ram_raddr !== 9'd0 || level !== 10'd1) begin
            miscompares++;
            $display("FAIL first_read_issue: ren=%b raddr=%0d level=%0d required 0 0 1", ram_ren, ram_raddr, level);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL first_latency_early: out_valid=%b required 0", out_valid);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || level !== 10'd1) begin
            miscompares++;
            $display("FAIL first_out: out_valid=%b out_data=%h level=%0d required 1 a5a50001 1",
                     out_valid, out_data, level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (empty !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL first_pop: empty=%b out_valid=%b required 1 0", empty, out_valid);
        end
        tick();
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 514; i++) begin
            in_valid = 1'b1; in_data = i;
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1 || level !== 10'(i) || almost_full !== (i >= 500)) begin
                miscompares++;
                $display("FAIL fill[%0d]: in_ready=%b level=%0d af=%b required 1 %0d %b",
                         i, in_ready, level, almost_full, i, (i >= 500));
            end
            tick();
        end
        in_valid = 1'b1; in_data = 32'd999;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || ram_wen !== 1'b1 || level !== 10'd514 || almost_full !== 1'b1 ||
            out_valid !== 1'b1 || out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL full: in_ready=%b wen=%b level=%0d af=%b out_valid=%b out_data=%0d required 0 1 514 1 1 0",
                     in_ready, ram_wen, level, almost_full, out_valid, out_data);
        end
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 514; j++) begin
            out_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'(j) || level !== 10'(514 - j)) begin
                miscompares++;
                $display("FAIL drain[%0d]: out_valid=%b out_data=%0d level=%0d required 1 %0d %0d",
                         j, out_valid, out_data, level, j, 514 - j);
            end
            if (j == 0) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_pop_blocked: in_ready=%b required 0", in_ready);
                end
            end
            if (j == 1) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_after_read: in_ready=%b required 1", in_ready);
                end
            end
            tick();
        end
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (empty !== 1'b1 || level !== 10'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drained: empty=%b level=%0d out_valid=%b required 1 0 0", empty, level, out_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        @(negedge clk);
        vectors++;
        if (level !== 10'd10 || out_valid !== 1'b1 || out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL prime: level=%0d out_valid=%b out_data=%0d required 10 1 0", level, out_valid, out_data);
        end
        tick();
        for (int k = 0; k < 2000; k++) begin
            in_valid = 1'b1; in_data = 10 + k; out_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'(k) || level !== 10'd10) begin
                miscompares++;
                $display("FAIL stream[%0d]: in_ready=%b out_valid=%b out_data=%0d level=%0d required 1 1 %0d 10",
                         k, in_ready, out_valid, out_data, level, k);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_d;
        logic [DW-1:0] hold_data = '0;
        logic          hold = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== hold_data) begin
                    miscompares++;
                    $display("FAIL rand_stable[%0d]: out_valid=%b out_data=%h required 1 %h", c, out_valid, out_data, hold_data);
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_pop[%0d]: got %h required nothing (scoreboard empty)", c, out_data);
                end else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin
                        miscompares++;
                        $display("FAIL rand_pop[%0d]: got %h required %h", c, out_data, exp_d);
                    end
                end
            end
            hold      = out_valid && !out_ready;
            hold_data = out_data;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (out_valid) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_drain: got %h required nothing", out_data);
                end else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin
                        miscompares++;
                        $display("FAIL rand_drain: got %h required %h", out_data, exp_d);
                    end
                end
            end
            tick();
            if (empty === 1'b1 && q.size() == 0) break;
        end
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (empty !== 1'b1 || q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_end: empty=%b left=%0d required 1 0", empty, q.size());
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        bit got;
        out_ready = 1'b0;
        for (int i = 0; i < 38; i++) begin
            in_valid = 1'b1; in_data = 32'h100 + i;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (ram_ren !== 1'b0 || level !== 10'd38) begin
            miscompares++;
            $display("FAIL mid_pop_issue: ren=%b level=%0d required 0 38", ram_ren, level);
        end
        tick();
        out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (level !== 10'd37 || in_ready !== 1'b0 || out_valid !== 1'b0 || ram_ren !== 1'b1 || ram_wen !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst_cycle: level=%0d in_ready=%b out_valid=%b ren=%b wen=%b required 37 0 0 1 1",
                     level, in_ready, out_valid, ram_ren, ram_wen);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (level !== 10'd0 || out_valid !== 1'b0 || ram_ren !== 1'b1 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_after_rst: level=%0d out_valid=%b ren=%b empty=%b required 0 0 1 1",
                     level, out_valid, ram_ren, empty);
        end
        in_valid = 1'b1; in_data = 32'h1234;
        tick();
        in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) got = 1'b1;
            else tick();
        end
        vectors++;
        if (!got || out_data !== 32'h1234) begin
            miscompares++;
            $display("FAIL mid_first_pop: out_valid_seen=%b out_data=%h required 1 00001234", got, out_data);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_first_word();
        test_reset();
        test_fill_drain();
        test_reset();
        test_back_to_back();
        test_reset();
        test_random();
        test_reset();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
